// File: rtl/y86_pkg.sv
// y86_pkg: Y86-64 icode/register constants, nop bundle values and decode helpers
package y86_pkg;
  localparam logic [3:0] I_HALT = 4'h0, I_NOP = 4'h1, I_CMOV = 4'h2, I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4, I_MRMOV = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8, I_RET = 4'h9, I_PUSH = 4'hA, I_POP = 4'hB;
  localparam logic [3:0] R_RSP = 4'h4, R_NONE = 4'hF;
  localparam logic       NOP_VALID = 1'b0;
  localparam logic [3:0] NOP_ICODE = I_NOP;
  function automatic logic [3:0] dec_src_a(input logic [3:0] icode, input logic [3:0] ra);
    return icode inside {I_CMOV, I_RMMOV, I_OPQ, I_PUSH} ? ra :
           icode inside {I_RET, I_POP} ? R_RSP : R_NONE;
  endfunction
  function automatic logic [3:0] dec_src_b(input logic [3:0] icode, input logic [3:0] rb);
    return icode inside {I_RMMOV, I_MRMOV, I_OPQ} ? rb :
           icode inside {I_CALL, I_RET, I_PUSH, I_POP} ? R_RSP : R_NONE;
  endfunction
  function automatic logic [3:0] dec_dst_e(input logic [3:0] icode, input logic [3:0] rb);
    return icode inside {I_CMOV, I_IRMOV, I_OPQ} ? rb :
           icode inside {I_CALL, I_RET, I_PUSH, I_POP} ? R_RSP : R_NONE;
  endfunction
  function automatic logic [3:0] dec_dst_m(input logic [3:0] icode, input logic [3:0] ra);
    return icode inside {I_MRMOV, I_POP} ? ra : R_NONE;
  endfunction
endpackage

// File: rtl/y86_regfile.sv
// y86_regfile: NREG x XLEN register file, 2 async read ports (id_a/id_b -> rd_a/rd_b), 2 sync write ports (dst_e/val_e, dst_m/val_m; M wins), sync reset loads RSP_RESET into %rsp
module y86_regfile import y86_pkg::*; #(
  parameter int XLEN = 64,
  parameter int NREG = 15,
  parameter logic [XLEN-1:0] RSP_RESET = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      id_a,
  input  logic [3:0]      id_b,
  output logic [XLEN-1:0] rd_a,
  output logic [XLEN-1:0] rd_b,
  input  logic [3:0]      dst_e,
  input  logic [XLEN-1:0] val_e,
  input  logic [3:0]      dst_m,
  input  logic [XLEN-1:0] val_m
);
  logic [XLEN-1:0] regs [NREG];
  logic we_e, we_m;
  assign rd_a = 32'(id_a) < NREG ? regs[id_a] : '0;
  assign rd_b = 32'(id_b) < NREG ? regs[id_b] : '0;
  assign we_e = dst_e != R_NONE && 32'(dst_e) < NREG;
  assign we_m = dst_m != R_NONE && 32'(dst_m) < NREG;
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < NREG; i++) regs[i] <= i == 32'(R_RSP) ? RSP_RESET : '0;
    else begin
      if (we_e) regs[dst_e] <= val_e;
      // the later assignment wins, so M overrides E on a shared destination
      if (we_m) regs[dst_m] <= val_m;
    end
endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: Y86-64 decode stage; decodes icode/rA/rB to register IDs, reads operands with M-over-E write-back forwarding, registers the result into D->E with stall/bubble; write-back ports wb_* update the internal file
module decode_pipe import y86_pkg::*; #(
  parameter int XLEN = 64,
  parameter int NREG = 15,
  parameter logic [XLEN-1:0] RSP_RESET = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [3:0]      icode,
  input  logic [3:0]      rA,
  input  logic [3:0]      rB,
  input  logic            stall,
  input  logic            bubble,
  input  logic [3:0]      wb_dstE,
  input  logic [3:0]      wb_dstM,
  input  logic [XLEN-1:0] wb_valE,
  input  logic [XLEN-1:0] wb_valM,
  output logic            out_valid,
  output logic [3:0]      out_icode,
  output logic [3:0]      out_srcA,
  output logic [3:0]      out_srcB,
  output logic [3:0]      out_dstE,
  output logic [3:0]      out_dstM,
  output logic [XLEN-1:0] out_valA,
  output logic [XLEN-1:0] out_valB
);
  logic [3:0] src_a, src_b, dst_e, dst_m;
  logic [XLEN-1:0] rd_a, rd_b, val_a, val_b;
  assign src_a = dec_src_a(icode, rA);
  assign src_b = dec_src_b(icode, rB);
  assign dst_e = dec_dst_e(icode, rB);
  assign dst_m = dec_dst_m(icode, rA);
  y86_regfile #(.XLEN(XLEN), .NREG(NREG), .RSP_RESET(RSP_RESET)) u_rf (
    .clk(clk), .reset(reset), .id_a(src_a), .id_b(src_b), .rd_a(rd_a), .rd_b(rd_b),
    .dst_e(wb_dstE), .val_e(wb_valE), .dst_m(wb_dstM), .val_m(wb_valM)
  );
  assign val_a = src_a == R_NONE ? '0 : src_a == wb_dstM ? wb_valM : src_a == wb_dstE ? wb_valE : rd_a;
  assign val_b = src_b == R_NONE ? '0 : src_b == wb_dstM ? wb_valM : src_b == wb_dstE ? wb_valE : rd_b;
  always_ff @(posedge clk)
    if (reset || (!stall && (bubble || !in_valid))) begin
      out_valid <= NOP_VALID;
      out_icode <= NOP_ICODE;
      out_srcA  <= R_NONE;
      out_srcB  <= R_NONE;
      out_dstE  <= R_NONE;
      out_dstM  <= R_NONE;
      out_valA  <= '0;
      out_valB  <= '0;
    end else if (!stall) begin
      out_valid <= 1'b1;
      out_icode <= icode;
      out_srcA  <= src_a;
      out_srcB  <= src_b;
      out_dstE  <= dst_e;
      out_dstM  <= dst_m;
      out_valA  <= val_a;
      out_valB  <= val_b;
    end
endmodule
